// File: rtl/corebootstrap_cksum_engine.sv
// Boot-copy checksum engine: sums data words, captures expected checksum from flash, flags mismatch.
// Latency: acc/word_count visible one cycle after the sampled word; done two edges after the final word/ref.
// Backpressure: none; one word per cycle sustained, words outside ACCUM and refs outside ACCUM/WAIT_REF are dropped.
module corebootstrap_cksum_engine #(
    parameter int CKSUM_EN   = 0,
    parameter int DATA_WIDTH = 32,
    parameter int CKSUM_MODE = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  start,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_last,
    input  logic                  cks_valid,
    input  logic [31:0]           cks_data,
    output logic                  busy,
    output logic                  cksum_done,
    output logic                  CKSUM_ERR,
    output logic [31:0]           cksum_value,
    output logic [CNT_WIDTH-1:0]  word_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ACCUM    = 3'd1,
        S_WAIT_REF = 3'd2,
        S_COMPARE  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    generate
        if (CKSUM_EN == 0) begin : g_stub
            // Legacy behaviour: the boot path always sees a clean, finished check.
            logic w_unused_inputs;
            assign w_unused_inputs = ^{HCLK, HRESET, start, data_valid, data_in,
                                       data_last, cks_valid, cks_data};
            assign busy        = 1'b0;
            assign cksum_done  = 1'b1;
            assign CKSUM_ERR   = 1'b0;
            assign cksum_value = 32'h0;
            assign word_count  = '0;
        end else begin : g_engine
            state_t               r_state;
            state_t               w_state_nxt;
            logic [31:0]          r_acc;
            logic [31:0]          r_ref;
            logic                 r_ref_held;
            logic [CNT_WIDTH-1:0] r_cnt;
            logic                 r_done;
            logic                 r_err;

            logic [31:0]          w_word;
            logic [31:0]          w_acc_nxt;
            logic [15:0]          w_fl_a;
            logic [15:0]          w_fl_b;
            logic                 w_clear;
            logic                 w_acc_upd;
            logic                 w_ref_ld;
            logic                 w_cmp;

            // Zero-extend the incoming word; the Fletcher variant only consumes 16 bits.
            always_comb begin
                w_word = 32'h0;
                w_word[DATA_WIDTH-1:0] = data_in;
                if (CKSUM_MODE == 2) begin
                    w_word[31:16] = 16'h0;
                end
            end

            // Next accumulator value for the selected algorithm.
            always_comb begin
                w_fl_a = r_acc[15:0] + w_word[15:0];
                w_fl_b = r_acc[31:16] + w_fl_a;
                case (CKSUM_MODE)
                    1:       w_acc_nxt = r_acc ^ w_word;
                    2:       w_acc_nxt = {w_fl_b, w_fl_a};
                    default: w_acc_nxt = r_acc + w_word;
                endcase
            end

            // State register.
            always_ff @(posedge HCLK or posedge HRESET) begin
                if (HRESET) begin
                    r_state <= S_IDLE;
                end else begin
                    r_state <= w_state_nxt;
                end
            end

            // Next state and datapath strobes; start overrides everything else in the cycle.
            always_comb begin
                w_state_nxt = r_state;
                w_clear     = 1'b0;
                w_acc_upd   = 1'b0;
                w_ref_ld    = 1'b0;
                w_cmp       = 1'b0;
                if (start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = S_ACCUM;
                end else begin
                    case (r_state)
                        S_ACCUM: begin
                            w_acc_upd = data_valid;
                            w_ref_ld  = cks_valid;
                            if (data_valid && data_last) begin
                                w_state_nxt = (r_ref_held || cks_valid) ? S_COMPARE : S_WAIT_REF;
                            end
                        end
                        S_WAIT_REF: begin
                            if (cks_valid) begin
                                w_ref_ld    = 1'b1;
                                w_state_nxt = S_COMPARE;
                            end
                        end
                        S_COMPARE: begin
                            w_cmp       = 1'b1;
                            w_state_nxt = S_DONE;
                        end
                        default: w_state_nxt = r_state;
                    endcase
                end
            end

            // Accumulator, saturating word counter, reference capture and result flags.
            always_ff @(posedge HCLK or posedge HRESET) begin
                if (HRESET) begin
                    r_acc      <= 32'h0;
                    r_ref      <= 32'h0;
                    r_ref_held <= 1'b0;
                    r_cnt      <= '0;
                    r_done     <= 1'b0;
                    r_err      <= 1'b0;
                end else if (w_clear) begin
                    r_acc      <= 32'h0;
                    r_ref      <= 32'h0;
                    r_ref_held <= 1'b0;
                    r_cnt      <= '0;
                    r_done     <= 1'b0;
                    r_err      <= 1'b0;
                end else begin
                    if (w_acc_upd) begin
                        r_acc <= w_acc_nxt;
                        if (r_cnt != {CNT_WIDTH{1'b1}}) begin
                            r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        end
                    end
                    if (w_ref_ld) begin
                        r_ref      <= cks_data;
                        r_ref_held <= 1'b1;
                    end
                    if (w_cmp) begin
                        r_err  <= (r_acc != r_ref);
                        r_done <= 1'b1;
                    end
                end
            end

            assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
            assign cksum_done  = r_done;
            assign CKSUM_ERR   = r_err;
            assign cksum_value = r_acc;
            assign word_count  = r_cnt;
        end
    endgenerate

endmodule

// File: tb/tb_corebootstrap_cksum_engine.sv
// Bench for corebootstrap_cksum_engine: three enabled variants (sum, XOR with 3-bit counter,
// 8-bit Fletcher) share one stimulus stream; a fourth instance checks the disabled stub.
// Expected results come from a list-based model and are checked by a decoupled monitor.
module tb_corebootstrap_cksum_engine;

    logic        HCLK;
    logic        HRESET;
    logic        start;
    logic        data_valid;
    logic [31:0] data_in;
    logic        data_last;
    logic        cks_valid;
    logic [31:0] cks_data;

    logic        busy0, busy1, busy2, busy3;
    logic        done0, done1, done2, done3;
    logic        err0, err1, err2, err3;
    logic [31:0] val0, val1, val2, val3;
    logic [15:0] cnt0, cnt2, cnt3;
    logic [2:0]  cnt1;

    corebootstrap_cksum_engine #(.CKSUM_EN(1), .DATA_WIDTH(32), .CKSUM_MODE(0), .CNT_WIDTH(16)) u_sum (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .data_valid(data_valid), .data_in(data_in),
        .data_last(data_last), .cks_valid(cks_valid), .cks_data(cks_data), .busy(busy0),
        .cksum_done(done0), .CKSUM_ERR(err0), .cksum_value(val0), .word_count(cnt0));

    corebootstrap_cksum_engine #(.CKSUM_EN(1), .DATA_WIDTH(32), .CKSUM_MODE(1), .CNT_WIDTH(3)) u_xor (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .data_valid(data_valid), .data_in(data_in),
        .data_last(data_last), .cks_valid(cks_valid), .cks_data(cks_data), .busy(busy1),
        .cksum_done(done1), .CKSUM_ERR(err1), .cksum_value(val1), .word_count(cnt1));

    corebootstrap_cksum_engine #(.CKSUM_EN(1), .DATA_WIDTH(8), .CKSUM_MODE(2), .CNT_WIDTH(16)) u_fl (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .data_valid(data_valid), .data_in(data_in[7:0]),
        .data_last(data_last), .cks_valid(cks_valid), .cks_data(cks_data), .busy(busy2),
        .cksum_done(done2), .CKSUM_ERR(err2), .cksum_value(val2), .word_count(cnt2));

    corebootstrap_cksum_engine #(.CKSUM_EN(0), .DATA_WIDTH(32), .CKSUM_MODE(0), .CNT_WIDTH(16)) u_stub (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .data_valid(data_valid), .data_in(data_in),
        .data_last(data_last), .cks_valid(cks_valid), .cks_data(cks_data), .busy(busy3),
        .cksum_done(done3), .CKSUM_ERR(err3), .cksum_value(val3), .word_count(cnt3));

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    // Per-instance views of the outputs.
    logic [2:0]  dn, bz, er;
    logic [31:0] vv [3];
    logic [15:0] cc [3];
    assign dn = {done2, done1, done0};
    assign bz = {busy2, busy1, busy0};
    assign er = {err2, err1, err0};
    assign vv[0] = val0;
    assign vv[1] = val1;
    assign vv[2] = val2;
    assign cc[0] = cnt0;
    assign cc[1] = {13'h0, cnt1};
    assign cc[2] = cnt2;

    typedef struct {
        logic [31:0] val;
        logic        err;
        int          cnt;
        int          cyc;
    } exp_t;

    exp_t q [3][$];

    // Reference model state: words accepted since the last start, captured reference.
    logic [31:0] m_words [$];
    logic [31:0] m_ref;
    logic        m_held;
    int          m_phase;   // 0 idle, 1 collecting, 2 awaiting ref, 3 comparing, 4 finished
    logic        exp_busy_now, exp_busy_nxt, exp_idle_now, exp_idle_nxt;
    logic        fin = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [31:0] model_cks(input int inst, input logic [31:0] ws[$]);
        logic [31:0] s;
        int unsigned a, b;
        s = 32'h0;
        a = 0;
        b = 0;
        foreach (ws[k]) begin
            if (inst == 0) begin
                s = s + ws[k];
            end else if (inst == 1) begin
                s = s ^ ws[k];
            end else begin
                a = (a + {24'h0, ws[k][7:0]}) % 65536;
                b = (b + a) % 65536;
                s = (b << 16) | a;
            end
        end
        return s;
    endfunction

    task automatic complete();
        exp_t x;
        int   cmax;
        for (int i = 0; i < 3; i++) begin
            cmax  = (i == 1) ? 7 : 65535;
            x.val = model_cks(i, m_words);
            x.err = (x.val != m_ref);
            x.cnt = (m_words.size() > cmax) ? cmax : m_words.size();
            x.cyc = cyc + 2;
            q[i].push_back(x);
        end
        m_phase = 3;
    endtask

    // Apply one cycle of inputs just after a rising edge and advance the model.
    task automatic issue(input logic st, input logic dv, input logic [31:0] d,
                         input logic ls, input logic cv, input logic [31:0] cd);
        start      = st;
        data_valid = dv;
        data_in    = d;
        data_last  = ls;
        cks_valid  = cv;
        cks_data   = cd;
        exp_busy_now = exp_busy_nxt;
        exp_idle_now = exp_idle_nxt;
        if (st) begin
            m_words = {};
            m_held  = 1'b0;
            m_ref   = 32'h0;
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (dv) m_words.push_back(d);
            if (cv) begin
                m_ref  = cd;
                m_held = 1'b1;
            end
            if (dv && ls) begin
                if (m_held) complete();
                else        m_phase = 2;
            end
        end else if (m_phase == 2) begin
            if (cv) begin
                m_ref = cd;
                complete();
            end
        end else if (m_phase == 3) begin
            m_phase = 4;
        end
        exp_busy_nxt = (m_phase >= 1) && (m_phase <= 3);
        exp_idle_nxt = (m_phase == 0);
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HRESET     = 1'b1;
        start      = 1'b0;
        data_valid = 1'b0;
        data_last  = 1'b0;
        cks_valid  = 1'b0;
        m_words    = {};
        m_held     = 1'b0;
        m_ref      = 32'h0;
        m_phase    = 0;
        exp_busy_now = 1'b0;
        exp_busy_nxt = 1'b0;
        exp_idle_now = 1'b1;
        exp_idle_nxt = 1'b1;
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: all output checking happens here, on the falling edge.
    exp_t       e;
    logic [2:0] pd = 3'b000;
    always @(negedge HCLK) begin
        chk("stub_outputs", {13'h0, busy3, done3, err3, val3, cnt3}, {13'h0, 3'b010, 32'h0, 16'h0});
        for (int i = 0; i < 3; i++) begin
            if (HRESET) begin
                chk($sformatf("reset_clear[%0d]", i), {13'h0, bz[i], dn[i], er[i], vv[i], cc[i]}, 64'h0);
            end else begin
                chk($sformatf("busy[%0d]", i), {63'h0, bz[i]}, {63'h0, exp_busy_now});
                if (exp_idle_now) begin
                    chk($sformatf("idle_outputs[%0d]", i), {14'h0, dn[i], er[i], vv[i], cc[i]}, 64'h0);
                end
                if (dn[i] && !pd[i]) begin
                    if (q[i].size() == 0) begin
                        chk($sformatf("unexpected_done[%0d]", i), {63'h0, dn[i]}, 64'h0);
                    end else begin
                        e = q[i].pop_front();
                        chk($sformatf("cksum_value[%0d]", i), {32'h0, vv[i]}, {32'h0, e.val});
                        chk($sformatf("cksum_err[%0d]", i), {63'h0, er[i]}, {63'h0, e.err});
                        chk($sformatf("word_count[%0d]", i), {48'h0, cc[i]}, 64'(e.cnt));
                        chk($sformatf("done_cycle[%0d]", i), 64'(cyc), 64'(e.cyc));
                    end
                end else if (q[i].size() > 0 && cyc > q[i][0].cyc) begin
                    chk($sformatf("done_timeout[%0d]", i), {63'h0, dn[i]}, 64'h1);
                    void'(q[i].pop_front());
                end
            end
            pd[i] = dn[i];
        end
        if (fin) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("results_outstanding[%0d]", i), 64'(q[i].size()), 64'h0);
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end

    // Stimulus.
    initial begin
        logic [31:0] ws [$];
        logic [31:0] refv;
        logic [31:0] cdk;
        logic        cvk;
        int          n, pos, j, tgt, abort_at;
        logic        junk;

        HRESET     = 1'b0;
        start      = 1'b0;
        data_valid = 1'b0;
        data_in    = 32'h0;
        data_last  = 1'b0;
        cks_valid  = 1'b0;
        cks_data   = 32'h0;
        #1;
        do_reset();

        // Words and refs before any start are ignored.
        repeat (2) issue(1'b0, 1'b1, $urandom, 1'b1, 1'b1, $urandom);

        // Sum: ref arrives ahead of the final word.
        issue(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        issue(1'b0, 1'b1, 32'h00000001, 1'b0, 1'b0, 32'h0);
        issue(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00000010);
        issue(1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0);
        issue(1'b0, 1'b1, 32'h00000010, 1'b1, 1'b0, 32'h0);
        repeat (3) issue(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // XOR: last word before ref, words ignored while waiting for the ref.
        issue(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        issue(1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0);
        issue(1'b0, 1'b1, 32'h0F0F0F0F, 1'b1, 1'b0, 32'h0);
        repeat (2) issue(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 32'h0);
        issue(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hAAAAAAAB);
        repeat (3) issue(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Fletcher bytes: ref in the same cycle as the last word.
        issue(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        issue(1'b0, 1'b1, 32'h00000001, 1'b0, 1'b0, 32'h0);
        issue(1'b0, 1'b1, 32'h00000002, 1'b1, 1'b1, 32'h00040003);
        repeat (3) issue(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Restart mid-stream; the word presented with the second start is dropped.
        issue(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        issue(1'b0, 1'b1, 32'h00000011, 1'b0, 1'b0, 32'h0);
        issue(1'b0, 1'b1, 32'h00000022, 1'b0, 1'b0, 32'h0);
        issue(1'b1, 1'b1, 32'h00000007, 1'b0, 1'b0, 32'h0);
        issue(1'b0, 1'b1, 32'h00000005, 1'b1, 1'b0, 32'h0);
        issue(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00000005);
        repeat (3) issue(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Reset after three words, then traffic without a start must be ignored.
        issue(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (3) issue(1'b0, 1'b1, $urandom, 1'b0, 1'b0, 32'h0);
        do_reset();
        repeat (3) issue(1'b0, 1'b1, $urandom, 1'b1, 1'b1, $urandom);

        // Randomised images: varying length, gaps, ref placement, stray refs and aborts.
        for (int t = 0; t < 40; t++) begin
            ws = {};
            n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) ws.push_back($urandom);
            pos = $urandom_range(0, 2);
            if (n == 1 && pos == 0) pos = 1;
            j = (pos == 0) ? $urandom_range(0, n - 2) : 0;
            tgt = $urandom_range(0, 3);
            refv = (tgt < 3) ? model_cks(tgt, ws) : $urandom;
            junk = ($urandom_range(0, 3) == 0);
            abort_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
            issue(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(0, 2)) issue(1'b0, 1'b0, $urandom, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
                if (k == abort_at) issue(1'b1, 1'b1, $urandom, 1'b0, 1'b0, 32'h0);
                if ((pos == 0 && k == j) || (pos == 1 && k == n - 1)) begin
                    cvk = 1'b1;
                    cdk = refv;
                end else if (junk && k == 0) begin
                    cvk = 1'b1;
                    cdk = $urandom;
                end else begin
                    cvk = 1'b0;
                    cdk = 32'h0;
                end
                issue(1'b0, 1'b1, ws[k], (k == n - 1), cvk, cdk);
            end
            if (pos == 2) begin
                repeat ($urandom_range(0, 3)) issue(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b1, 1'b0, 32'h0);
                issue(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, refv);
            end
            repeat ($urandom_range(2, 4)) issue(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        end

        repeat (4) issue(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        fin = 1'b1;
    end

endmodule

// File: doc/corebootstrap_cksum_engine.md
# corebootstrap_cksum_engine

Parametrised checksum engine for the boot-copy path. Accumulates a running checksum over each data word that the SPI reader marks valid, captures the expected checksum read from flash, and flags a mismatch to the AHB writer. It replaces the fixed stub (done tied high, error tied low) with a real accumulator and selectable algorithm. With CKSUM_EN=0 it keeps the stub behaviour.

## Interface
- CKSUM_EN, 0: 1 = compute and compare; 0 = cksum_done tied 1, CKSUM_ERR tied 0, all other outputs 0
- DATA_WIDTH, 32: width of data_in; legal 8, 16, 32
- CKSUM_MODE, 0: 0 = additive sum mod 2^32; 1 = XOR fold; 2 = Fletcher-style 16+16 (requires DATA_WIDTH ≤ 16)
- CNT_WIDTH, 16: width of word counter

- HCLK  in  1  clock, all logic rising-edge
- HRESET  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: clear accumulator/counter/ref, enter ACCUM
- data_valid  in  1  data_in valid this cycle; low while the checksum field itself is streamed
- data_in  in  DATA_WIDTH  data word
- data_last  in  1  qualifies data_valid: final word of image
- cks_valid  in  1  cks_data valid this cycle
- cks_data  in  32  expected checksum from flash
- busy  out  1  state ≠ IDLE and ≠ DONE
- cksum_done  out  1  comparison complete; held until start or reset
- CKSUM_ERR  out  1  computed ≠ expected; valid when cksum_done=1, held
- cksum_value  out  32  current accumulator
- word_count  out  CNT_WIDTH  words accepted since start, saturating

## Operation
- Reset (any state, any time): state=IDLE; busy=0, cksum_done=0, CKSUM_ERR=0, cksum_value=0, word_count=0, ref/ref_held/last_seen cleared.
- Word w = data_in zero-extended to 32 (mode 2: low 16 bits).
- Mode 0: acc ← acc + w mod 2^32. Mode 1: acc ← acc ^ w. Mode 2: A ← (A + w) mod 2^16; B ← (B + A_new) mod 2^16; acc = {B, A}.
- States: IDLE, ACCUM, WAIT_REF, COMPARE, DONE.
- IDLE/DONE: start → ACCUM (clears acc, count, ref_held, last_seen, cksum_done, CKSUM_ERR). data_valid/cks_valid ignored.
- ACCUM: data_valid → update acc, count+1 (saturate at all-ones). cks_valid → latch ref, ref_held=1 (later cks_valid overwrites). data_valid&data_last → if ref_held or cks_valid same cycle → COMPARE, else → WAIT_REF.
- WAIT_REF: data_valid ignored. cks_valid → latch ref → COMPARE.
- COMPARE: single cycle; CKSUM_ERR ← (acc ≠ ref); cksum_done ← 1; → DONE.
- start in any state restarts: start has priority; data_valid/cks_valid in the same cycle are dropped.
- Simultaneous data_last and cks_valid in ACCUM: both taken, the final word is included, → COMPARE.

## Timing
- acc/word_count update on the edge that samples data_valid; visible next cycle.
- Last word (ref already held) sampled at edge N: COMPARE during cycle N..N+1; cksum_done=1, CKSUM_ERR valid after edge N+1.
- Ref arriving in WAIT_REF at edge M: cksum_done after edge M+1.
- start sampled at edge S: busy=1, cksum_done=0, acc=0 after edge S.
- No backpressure: one word per cycle sustained; data_valid may be asserted every cycle.
- HRESET assertion clears outputs asynchronously; the first start is accepted on the first edge after deassertion.

## Test plan
- Mode 0, 32-bit: start; words 0x00000001, 0xFFFFFFFF, 0x00000010 (last); cks_data=0x00000010 sent before the last word -> cksum_value=0x00000010, CKSUM_ERR=0, cksum_done 2 edges after the last word, word_count=3.
- Mode 1: words 0xA5A5A5A5, 0x0F0F0F0F (last), no ref yet -> WAIT_REF, busy=1; cks_valid with 0xAAAAAAAB -> CKSUM_ERR=1, cksum_done=1, cksum_value=0xAAAAAAAA.
- Mode 2, DATA_WIDTH=8: bytes 0x01, 0x02 (last), cks_valid same cycle as last with 0x00040003 -> cksum_value=0x00040003, CKSUM_ERR=0.
- Restart: start, 2 words, start again with data_valid same cycle, then word 0x5 (last), ref 0x5 -> word_count=1, CKSUM_ERR=0.
- Reset mid-ACCUM after 3 words -> all outputs 0 immediately, state IDLE; data_valid ignored until start.
- CKSUM_EN=0: any stimulus -> cksum_done=1, CKSUM_ERR=0 from reset onward.
